// File: rtl/cla_addsub_mc.sv
// Multi-cycle add/subtract unit resolving SLICE bits per cycle with a carry-lookahead slice.
// Optional signed saturation is enabled by defining CLA_ADDSUB_SAT_EN (adds the sat input).
module cla_addsub_mc #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CLA_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int K    = WIDTH / SLICE;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  sliceIdx_q;
    logic [WIDTH-1:0] xOp_q;
    logic [WIDTH-1:0] yOp_q;
    logic [WIDTH-1:0] sum_q;
    logic             sliceCin_q;
    logic             satOp_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] z_q;
    logic             carry_q;
    logic             overflow_q;
    logic             negative_q;
    logic             zero_q;

    logic             satIn;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carries;
    logic [SLICE-1:0] sliceSum;
    logic             term;
    logic             prodTerm;
    logic [WIDTH-1:0] sumFull;
    logic             ovf;
    logic [WIDTH-1:0] z_d;

`ifdef CLA_ADDSUB_SAT_EN
    assign satIn = sat;
`else
    assign satIn = 1'b0;
`endif

    assign sliceA = xOp_q[sliceIdx_q*SLICE +: SLICE];
    assign sliceB = yOp_q[sliceIdx_q*SLICE +: SLICE];

    // Each carry is a flat sum of generate/propagate products rather than a ripple chain.
    always_comb begin
        gen        = sliceA & sliceB;
        prop       = sliceA ^ sliceB;
        carries    = '0;
        carries[0] = sliceCin_q;
        term       = 1'b0;
        prodTerm   = 1'b0;
        for (int k = 0; k < SLICE; k++) begin
            term = sliceCin_q;
            for (int j = 0; j <= k; j++) begin
                term = term & prop[j];
            end
            for (int j = 0; j <= k; j++) begin
                prodTerm = gen[j];
                for (int m = j + 1; m <= k; m++) begin
                    prodTerm = prodTerm & prop[m];
                end
                term = term | prodTerm;
            end
            carries[k+1] = term;
        end
        sliceSum = prop ^ carries[SLICE-1:0];
    end

    always_comb begin
        sumFull = sum_q;
        sumFull[sliceIdx_q*SLICE +: SLICE] = sliceSum;
        ovf = (xOp_q[WIDTH-1] == yOp_q[WIDTH-1]) && (sumFull[WIDTH-1] != xOp_q[WIDTH-1]);
        z_d = sumFull;
        if (satOp_q && ovf) begin
            z_d = xOp_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // The operand register holds y already inverted for subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sliceIdx_q <= '0;
            xOp_q      <= '0;
            yOp_q      <= '0;
            sum_q      <= '0;
            sliceCin_q <= 1'b0;
            satOp_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            z_q        <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xOp_q      <= x;
                        yOp_q      <= op[0] ? ~y : y;
                        sliceCin_q <= op[1] ? carry_q : op[0];
                        satOp_q    <= satIn;
                        sliceIdx_q <= '0;
                        sum_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q      <= sumFull;
                    sliceCin_q <= carries[SLICE];
                    sliceIdx_q <= sliceIdx_q + 1'b1;
                    if (sliceIdx_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        z_q        <= z_d;
                        carry_q    <= carries[SLICE];
                        overflow_q <= ovf;
                        negative_q <= z_d[WIDTH-1];
                        zero_q     <= (z_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign z        = z_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign negative = negative_q;
    assign zero     = zero_q;

endmodule

// File: doc/cla_addsub_mc.md
CLA_ADDSUB_MC -- requirements
Module: cla_addsub_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width; a multiple of SLICE, at least 8.
REQ-002 SHALL have parameter SLICE, default 4: bits resolved per RUN cycle by an internal carry-lookahead slice; SLICE==WIDTH allowed.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port op, input, 2: operation; 00 add, 01 sub, 10 adc, 11 sbc.
REQ-007 SHALL have ports x and y, input, WIDTH each: operands.
REQ-008 SHALL have port busy, output, 1: high while in RUN.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port z, output, WIDTH: registered result.
REQ-011 SHALL have ports carry, overflow, negative and zero, output, 1 each: registered flags.

Function
REQ-012 SHALL have states IDLE and RUN; K = WIDTH/SLICE.
REQ-013 SHALL, on an edge N in IDLE with start=1, latch x, y and op, clear the slice index, and enter RUN.
REQ-014 SHALL, at edges N+1..N+K, resolve slice i (bits i*SLICE..i*SLICE+SLICE-1), using the carry from slice i-1 as that slice's carry-in.
REQ-015 SHALL, at edge N+K, register z and all flags, return to IDLE, and hold done=1 for exactly the cycle that follows.
REQ-016 SHALL hold busy=1 from edge N+1 up to edge N+K.
REQ-017 SHALL ignore start while in RUN: no relatch, no effect.
REQ-018 SHALL accept a start sampled in the cycle where done=1, so back-to-back operation has no gap cycle.
REQ-019 SHALL compute the result as x + y', plus a carry-in: y' = y for add/adc, y' = ~y for sub/sbc; carry-in = 0 for add, 1 for sub, and the stored carry flag for adc/sbc.
REQ-020 SHALL set carry to the carry out of bit WIDTH-1; for subtraction, carry=1 means no borrow.
REQ-021 SHALL set overflow when x[MSB] == y'[MSB] and z[MSB] differs from them.
REQ-022 SHALL set negative = z[MSB], and zero = 1 only when all WIDTH bits of z are 0.
REQ-023 SHALL hold z and all flags stable between completions; they SHALL change only at edge N+K.
REQ-024 SHALL sample the carry flag used by adc/sbc at edge N, i.e. the value left by the previous completion.

Reset
REQ-025 SHALL, while rst_n=0, immediately force IDLE, busy=0, done=0, z=0, carry=0, overflow=0, negative=0 and zero=0.
REQ-026 SHALL discard a RUN in progress when reset is asserted, and SHALL NOT pulse done for it after reset release.
REQ-027 SHALL accept start on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL support macro CLA_ADDSUB_SAT_EN; when defined, the module SHALL add input port sat (1 bit), sampled at edge N.
REQ-029 SHALL, with CLA_ADDSUB_SAT_EN defined and sat=1, replace an overflowing result with signed saturation: 0111..1 when x[MSB]=0, 1000..0 when x[MSB]=1.
REQ-030 SHALL, for a saturated result, keep overflow=1 and carry per REQ-020, and derive negative and zero from the saturated z.
REQ-031 SHALL, without CLA_ADDSUB_SAT_EN, have no sat port and always wrap modulo 2^WIDTH.

Verification (WIDTH=16, SLICE=4, K=4)
REQ-032 SHALL cover add 0x7FFF+0x0001, start at edge N -> busy high at edges N+1..N+3, done high only in the cycle after edge N+4, z=0x8000, V=1, N=1, C=0, Z=0.
REQ-033 SHALL cover add 0xFFFF+0x0001 then adc 0x0000+0x0000 -> first z=0x0000, C=1, Z=1; second z=0x0001, C=0, Z=0.
REQ-034 SHALL cover sub 0x0050-0x0030 -> z=0x0020, C=1; then sub 0x001E-0x0032 -> z=0xFFEC, C=0, N=1, V=0.
REQ-035 SHALL cover start pulsed during busy with different operands -> no effect, and the original result completes at edge N+4; a start in the done cycle completes 4 edges later.
REQ-036 SHALL cover rst_n low at edge N+2 of an add -> all outputs 0 at once, no done pulse after release.
REQ-037 SHALL cover, with CLA_ADDSUB_SAT_EN: sat=1 add 0x7FFF+0x0001 -> z=0x7FFF, V=1, N=0; sat=1 sub 0x8000-0x0001 -> z=0x8000, V=1, N=1.
